// File: rtl/lfo_multi.sv
// Multi-shape LFO: phase accumulator with retrigger, triangle/saw/square/sample-and-hold
// waveforms from a free-running LFSR, and a registered depth-scaled output.
module lfo_multi #(
    parameter int OUT_WIDTH   = 10,
    parameter int PHASE_WIDTH = 24,
    parameter int RATE_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RATE_WIDTH-1:0] rate,
    input  logic [2:0]            shape,
    input  logic [7:0]            depth,
    input  logic                  retrigger,
    output logic [OUT_WIDTH-1:0]  out,
    output logic                  cycle_start
);

    localparam logic [2:0] SHAPE_SAW_UP   = 3'd1;
    localparam logic [2:0] SHAPE_SAW_DOWN = 3'd2;
    localparam logic [2:0] SHAPE_SQUARE   = 3'd3;
    localparam logic [2:0] SHAPE_SH       = 3'd4;

    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH:0]   sum;
    logic                   wrap;
    logic                   period_event;
    logic [15:0]            lfsr;
    logic [15:0]            lfsr_next;
    logic [OUT_WIDTH-1:0]   sh_src;
    logic [OUT_WIDTH-1:0]   sh_value;
    logic [OUT_WIDTH:0]     t;
    logic [OUT_WIDTH-1:0]   s;
    logic [OUT_WIDTH-1:0]   raw;
    logic [8:0]             depth_p1;
    logic [OUT_WIDTH-1:0]   out_next;

    // Carry-out of the accumulator add marks the end of an LFO period.
    assign sum          = {1'b0, phase} + {{(PHASE_WIDTH + 1 - RATE_WIDTH){1'b0}}, rate};
    assign wrap         = sum[PHASE_WIDTH];
    assign period_event = wrap | retrigger;

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    generate
        if (OUT_WIDTH <= 16) begin : g_sh_narrow
            assign sh_src = lfsr[15 -: OUT_WIDTH];
        end else begin : g_sh_wide
            assign sh_src = {lfsr, {(OUT_WIDTH - 16){1'b0}}};
        end
    endgenerate

    assign t = phase[PHASE_WIDTH-1 -: OUT_WIDTH+1];
    assign s = phase[PHASE_WIDTH-1 -: OUT_WIDTH];

    always_comb begin
        raw = '0;
        case (shape)
            SHAPE_SAW_UP:   raw = s;
            SHAPE_SAW_DOWN: raw = ~s;
            SHAPE_SQUARE:   raw = phase[PHASE_WIDTH-1] ? '0 : {OUT_WIDTH{1'b1}};
            SHAPE_SH:       raw = sh_value;
            default:        raw = t[OUT_WIDTH] ? ~t[OUT_WIDTH-1:0] : t[OUT_WIDTH-1:0];
        endcase
    end

    // depth+1 makes 255 a unity gain; the product never exceeds raw << 8.
    assign depth_p1 = {1'b0, depth} + 9'd1;
    assign out_next = OUT_WIDTH'(({9'd0, raw} * {{OUT_WIDTH{1'b0}}, depth_p1}) >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= '0;
            lfsr        <= 16'hACE1;
            sh_value    <= '0;
            out         <= '0;
            cycle_start <= 1'b0;
        end else begin
            phase       <= retrigger ? '0 : sum[PHASE_WIDTH-1:0];
            lfsr        <= lfsr_next;
            if (period_event) begin
                sh_value <= sh_src;
            end
            out         <= out_next;
            cycle_start <= period_event;
        end
    end

endmodule
